// File: rtl/traffic_intersection.sv
// traffic_intersection
//   Two-approach traffic-light controller. Main approach A and side
//   approach B cycle through green, yellow and all-red clearance phases.
//   B is only served when a side request has been latched; otherwise A's
//   green is extended. Night mode routes through the all-red clearance
//   into a yellow flash on both approaches.
//
// Ports
//   in_clk      clock, rising edge
//   in_rst      asynchronous active-high reset
//   in_srt      start pulse, only acted on in IDLE
//   in_req_b    side-approach request (level or pulse)
//   in_night    night/flash mode request, evaluated at phase ends
//   o_green     green lamps  {B, A}
//   o_yellow    yellow lamps {B, A}
//   o_red       red lamps    {B, A}
//   o_count     cycles remaining in current phase minus one
//   o_req_pend  side request latched and not yet served
//
// All outputs are registered. Lamp values are decoded from the next state
// so that they change on the same edge as the state register.
module traffic_intersection #(
    parameter int CNT_W    = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int FLASH_T  = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_srt,
    input  logic             in_req_b,
    input  logic             in_night,
    output logic [1:0]       o_green,
    output logic [1:0]       o_yellow,
    output logic [1:0]       o_red,
    output logic [CNT_W-1:0] o_count,
    output logic             o_req_pend
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        A_CLR = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        B_CLR = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_q, req_d;
    logic             flash_on_q, flash_on_d;
    logic [1:0]       green_q, green_d;
    logic [1:0]       yellow_q, yellow_d;
    logic [1:0]       red_q, red_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        req_d      = req_q;
        flash_on_d = flash_on_q;

        // Requests are only collected while A owns the intersection.
        if (in_req_b && (state_q == IDLE || state_q == A_GRN ||
                         state_q == A_YEL || state_q == A_CLR)) begin
            req_d = 1'b1;
        end

        if (state_q == IDLE) begin
            count_d = '0;
            if (in_srt) begin
                state_d = A_GRN;
                count_d = GREEN_LD;
            end
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            // Phase end: every branch reloads the counter for the phase entered.
            case (state_q)
                A_GRN: begin
                    if (in_night || req_q) begin
                        state_d = A_YEL;
                        count_d = YELLOW_LD;
                    end else begin
                        count_d = GREEN_LD;
                    end
                end
                A_YEL: begin
                    state_d = A_CLR;
                    count_d = ALLRED_LD;
                end
                A_CLR, B_CLR: begin
                    if (in_night) begin
                        state_d    = FLASH;
                        count_d    = FLASH_LD;
                        flash_on_d = 1'b1;
                    end else if (state_q == A_CLR) begin
                        state_d = B_GRN;
                        count_d = GREEN_LD;
                    end else begin
                        state_d = A_GRN;
                        count_d = GREEN_LD;
                    end
                end
                B_GRN: begin
                    state_d = B_YEL;
                    count_d = YELLOW_LD;
                end
                B_YEL: begin
                    state_d = B_CLR;
                    count_d = ALLRED_LD;
                end
                FLASH: begin
                    flash_on_d = ~flash_on_q;
                    if (!in_night) begin
                        state_d = B_CLR;
                        count_d = ALLRED_LD;
                    end else begin
                        count_d = FLASH_LD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        // Serving B consumes the request; this wins over a same-edge set.
        if (state_d == B_GRN && state_q != B_GRN) begin
            req_d = 1'b0;
        end

        green_d  = 2'b00;
        yellow_d = 2'b00;
        red_d    = 2'b11;
        case (state_d)
            A_GRN: begin
                green_d = 2'b01;
                red_d   = 2'b10;
            end
            A_YEL: begin
                yellow_d = 2'b01;
                red_d    = 2'b10;
            end
            B_GRN: begin
                green_d = 2'b10;
                red_d   = 2'b01;
            end
            B_YEL: begin
                yellow_d = 2'b10;
                red_d    = 2'b01;
            end
            FLASH: begin
                red_d    = 2'b00;
                yellow_d = flash_on_d ? 2'b11 : 2'b00;
            end
            default: begin
                red_d = 2'b11;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            req_q      <= 1'b0;
            flash_on_q <= 1'b0;
            green_q    <= 2'b00;
            yellow_q   <= 2'b00;
            red_q      <= 2'b11;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            req_q      <= req_d;
            flash_on_q <= flash_on_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
        end
    end

    assign o_green    = green_q;
    assign o_yellow   = yellow_q;
    assign o_red      = red_q;
    assign o_count    = count_q;
    assign o_req_pend = req_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection
//   Directed scenarios with literal expectations, followed by randomized
//   stimulus. A phase-level reference model (phase name, cycles left in the
//   phase, request flag, flash half) predicts the lamps, countdown and
//   pending flag, and is compared against the DUT on every falling edge.
module tb_traffic_intersection;

    localparam int CNT_W = 4;
    localparam int G_T = 8;
    localparam int Y_T = 3;
    localparam int R_T = 2;
    localparam int F_T = 4;

    // Phase codes used by the model only.
    localparam int P_IDLE = 0, P_AG = 1, P_AY = 2, P_AC = 3;
    localparam int P_BG = 4, P_BY = 5, P_BC = 6, P_FL = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             srt = 1'b0;
    logic             req_b = 1'b0;
    logic             night = 1'b0;
    logic [1:0]       o_green, o_yellow, o_red;
    logic [CNT_W-1:0] o_count;
    logic             o_req_pend;

    int checks = 0;
    int failures = 0;

    traffic_intersection #(
        .CNT_W(CNT_W), .GREEN_T(G_T), .YELLOW_T(Y_T),
        .ALLRED_T(R_T), .FLASH_T(F_T)
    ) dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_srt    (srt),
        .in_req_b  (req_b),
        .in_night  (night),
        .o_green   (o_green),
        .o_yellow  (o_yellow),
        .o_red     (o_red),
        .o_count   (o_count),
        .o_req_pend(o_req_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_ph = P_IDLE;
    int m_left = 1;     // cycles left in the phase including the current one
    bit m_req = 1'b0;
    bit m_on = 1'b0;

    task automatic m_enter(input int ph, input int dur);
        m_ph = ph;
        m_left = dur;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = P_IDLE;
            m_left = 1;
            m_req = 1'b0;
            m_on = 1'b0;
        end else begin
            bit req_new;
            req_new = m_req;
            if (req_b && m_ph <= P_AC) req_new = 1'b1;
            if (m_ph == P_IDLE) begin
                if (srt) m_enter(P_AG, G_T);
            end else if (m_left > 1) begin
                m_left--;
            end else begin
                case (m_ph)
                    P_AG: if (night || m_req) m_enter(P_AY, Y_T); else m_enter(P_AG, G_T);
                    P_AY: m_enter(P_AC, R_T);
                    P_AC: begin
                        if (night) begin m_enter(P_FL, F_T); m_on = 1'b1; end
                        else begin m_enter(P_BG, G_T); req_new = 1'b0; end
                    end
                    P_BG: m_enter(P_BY, Y_T);
                    P_BY: m_enter(P_BC, R_T);
                    P_BC: begin
                        if (night) begin m_enter(P_FL, F_T); m_on = 1'b1; end
                        else m_enter(P_AG, G_T);
                    end
                    default: begin
                        m_on = !m_on;
                        if (!night) m_enter(P_BC, R_T); else m_enter(P_FL, F_T);
                    end
                endcase
            end
            m_req = req_new;
        end
    end

    // Lamp table per phase.
    function automatic int exp_green(input int ph);
        return (ph == P_AG) ? 1 : (ph == P_BG) ? 2 : 0;
    endfunction
    function automatic int exp_yellow(input int ph, input bit on);
        if (ph == P_AY) return 1;
        if (ph == P_BY) return 2;
        if (ph == P_FL) return on ? 3 : 0;
        return 0;
    endfunction
    function automatic int exp_red(input int ph);
        case (ph)
            P_AG, P_AY: return 2;
            P_BG, P_BY: return 1;
            P_FL:       return 0;
            default:    return 3;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_green", o_green, exp_green(m_ph));
            chk("model_yellow", o_yellow, exp_yellow(m_ph, m_on));
            chk("model_red", o_red, exp_red(m_ph));
            chk("model_count", o_count, (m_ph == P_IDLE) ? 0 : m_left - 1);
            chk("model_req_pend", o_req_pend, m_req);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int found;
        int b_seen;

        // Reset and idle
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0 || i == 9) begin
                chk("idle_red", o_red, 3);
                chk("idle_green", o_green, 0);
                chk("idle_yellow", o_yellow, 0);
                chk("idle_count", o_count, 0);
            end
        end

        // Start without request: green extension
        srt = 1'b1; step(); srt = 1'b0;
        chk("start_green", o_green, 1);
        chk("start_count", o_count, 7);
        for (int i = 0; i < 8; i++) step();
        chk("ext_green", o_green, 1);
        chk("ext_count", o_count, 7);
        b_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_green[1] || o_red[1] == 1'b0) b_seen = 1;
        end
        chk("no_b_without_req", b_seen, 0);

        // Async reset mid A_GRN
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_red", o_red, 3);
        chk("async_rst_green", o_green, 0);
        chk("async_rst_count", o_count, 0);
        step(); rst = 1'b0;

        // Full cycle with request in cycle 3 of A_GRN
        srt = 1'b1; step(); srt = 1'b0;          // E0: A_GRN count 7
        step(); step();                           // E1, E2
        req_b = 1'b1; step(); req_b = 1'b0;       // E3
        chk("req_latched", o_req_pend, 1);
        chk("req_count", o_count, 4);
        for (int i = 0; i < 10; i++) step();     // E13
        chk("bgrn_green", o_green, 2);
        chk("bgrn_count", o_count, 7);
        chk("bgrn_req_clr", o_req_pend, 0);
        for (int i = 0; i < 13; i++) step();     // E26
        chk("back_agrn_green", o_green, 1);
        chk("back_agrn_count", o_count, 7);

        // Request during B phase is ignored
        req_b = 1'b1; step(); req_b = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (o_green == 2'b10) found = 1;
        end
        chk("reach_bgrn", found, 1);
        req_b = 1'b1; step(); step(); req_b = 1'b0;
        chk("b_req_ignored", o_req_pend, 0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (o_green == 2'b01) found = 1;
        end
        chk("reach_agrn", found, 1);
        for (int i = 0; i < 8; i++) step();
        chk("agrn_extends", o_green, 1);
        chk("agrn_ext_count", o_count, 7);

        // Night entry and exit
        night = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (o_yellow == 2'b11) found = 1;
        end
        chk("flash_entered", found, 1);
        chk("flash_red", o_red, 0);
        for (int i = 0; i < 4; i++) step();
        chk("flash_off", o_yellow, 0);
        for (int i = 0; i < 4; i++) step();
        chk("flash_on_again", o_yellow, 3);
        night = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (o_red == 2'b11) found = 1;
        end
        chk("flash_exit_bclr", found, 1);
        chk("bclr_count", o_count, 1);
        step(); step();
        chk("after_flash_green", o_green, 1);
        chk("after_flash_count", o_count, 7);

        // Night and request together
        req_b = 1'b1; step(); req_b = 1'b0;
        night = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (o_yellow == 2'b11 && o_red == 2'b00) found = 1;
        end
        chk("sim_flash", found, 1);
        chk("sim_req_kept", o_req_pend, 1);
        for (int i = 0; i < 6; i++) step();
        chk("sim_req_kept_later", o_req_pend, 1);
        night = 1'b0;

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            srt   = ($urandom_range(0, 99) < 5);
            req_b = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 3) night = ~night;
            rst   = ($urandom_range(0, 999) < 3);
        end
        @(negedge clk); #1;
        rst = 1'b0; srt = 1'b0; req_b = 1'b0; night = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
